ahb_lite_cmd_master: RTL and testbench

AHB-Lite initiator that turns a simple valid/ready command stream into single-word AHB-Lite transfers. It drives the bus into the team's AHB peripherals (VGA text console, lockstep VGA pair, GPIO, timers) without a CPU. Applications are hardware test generators and DMA-style character writers. It buffers commands in a small FIFO and issues pipelined NONSEQ transfers, overlapping one address phase with the previous data phase. It honours slave wait states and returns one response per command.

---
 rtl/ahb_lite_cmd_master_if.sv | 36 +++
 rtl/ahb_lite_cmd_master.sv | 134 +++++++++++++
 tb/tb_ahb_lite_cmd_master.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_cmd_master_if.sv
// Bundle for the command stream, the response stream and the AHB-Lite
// initiator port of ahb_lite_cmd_master.
interface ahb_lite_cmd_master_if;
  // command stream
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  // response stream
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        busy;
  // AHB-Lite initiator side
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADY, HRDATA,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy,
           HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADY, HRDATA,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy,
           HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );
endinterface

// File: rtl/ahb_lite_cmd_master.sv
// Command-stream to AHB-Lite single-word initiator. Commands are queued in a
// small FIFO; the FIFO head drives the address phase directly so one address
// phase overlaps the previous data phase, giving one transfer per cycle.
module ahb_lite_cmd_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_lite_cmd_master_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  typedef struct packed {
    logic        write;
    logic [29:0] word_addr;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  cmd_t             head;
  cmd_t             push_entry;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // address-phase hold values used while the FIFO is empty
  logic [29:0]      last_addr;
  logic             last_write;

  // data-phase state
  logic             dp_valid;
  logic             dp_write;
  logic [31:0]      hwdata;

  // response registers
  logic             rsp_valid;
  logic             rsp_write;
  logic [31:0]      rsp_rdata;

  // byte-lane bits of the command address are dropped by design
  logic             unused_addr_bits;
  assign unused_addr_bits = ^bus.cmd_addr[1:0];

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = bus.cmd_valid & ~full;
  // an address is accepted whenever NONSEQ is driven and the bus is ready
  assign pop   = bus.HREADY & ~empty;
  assign head  = fifo_mem[rd_ptr];

  assign push_entry.write     = bus.cmd_write;
  assign push_entry.word_addr = bus.cmd_addr[31:2];
  assign push_entry.wdata     = bus.cmd_wdata;

  // FIFO storage: no reset needed, occupancy is tracked by count
  always_ff @(posedge HCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers and occupancy; reset flushes the queue
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // remember the last accepted address phase so HADDR/HWRITE hold when idle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_addr  <= '0;
      last_write <= 1'b0;
    end else if (pop) begin
      last_addr  <= head.word_addr;
      last_write <= head.write;
    end
  end

  // data phase: loads on address acceptance, everything holds during waits
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      hwdata   <= '0;
    end else if (bus.HREADY) begin
      dp_valid <= pop;
      if (pop) begin
        dp_write <= head.write;
        if (head.write) hwdata <= head.wdata;
      end
    end
  end

  // one response pulse per completed data phase; reads capture HRDATA
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= dp_valid & bus.HREADY;
      if (dp_valid && bus.HREADY) begin
        rsp_write <= dp_write;
        if (!dp_write) rsp_rdata <= bus.HRDATA;
      end
    end
  end

  assign bus.cmd_ready = ~full;
  assign bus.busy      = ~empty | dp_valid;
  assign bus.HTRANS    = empty ? 2'b00 : 2'b10;
  assign bus.HADDR     = empty ? {last_addr, 2'b00} : {head.word_addr, 2'b00};
  assign bus.HWRITE    = empty ? last_write : head.write;
  assign bus.HSIZE     = 3'b010;
  assign bus.HBURST    = 3'b000;
  assign bus.HWDATA    = hwdata;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_write = rsp_write;
  assign bus.rsp_rdata = rsp_rdata;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master with a word-memory slave model.
module tb_ahb_lite_cmd_master;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_lite_cmd_master_if bus ();

  ahb_lite_cmd_master #(.FIFO_DEPTH(4)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // slave model state
  logic [31:0] smem [64];
  logic        s_dp_valid = 1'b0;
  logic        s_dp_write = 1'b0;
  logic [31:0] s_dp_addr  = '0;
  logic        mon_ready = 1'b0, mon_acc = 1'b0, mon_write = 1'b0, mon_done = 1'b0;
  logic [31:0] mon_addr = '0, mon_wdata = '0;

  int          rsp_cyc_q  [$];
  logic [31:0] rsp_data_q [$];
  logic        rsp_wr_q   [$];
  logic [31:0] acc_q      [$];

  assign bus.HRDATA = smem[s_dp_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // sample the bus mid-cycle: these values are what the next rising edge sees
  always @(negedge HCLK) begin
    mon_ready = bus.HREADY;
    mon_acc   = bus.HREADY && (bus.HTRANS == 2'b10);
    mon_addr  = bus.HADDR;
    mon_write = bus.HWRITE;
    mon_done  = bus.HREADY && s_dp_valid;
    mon_wdata = bus.HWDATA;
    if (mon_acc) acc_q.push_back(bus.HADDR);
    if (bus.rsp_valid) begin
      rsp_cyc_q.push_back(cyc);
      rsp_data_q.push_back(bus.rsp_rdata);
      rsp_wr_q.push_back(bus.rsp_write);
      $display("[TB] cycle %0d rsp write=%0b rdata=0x%08h", cyc, bus.rsp_write, bus.rsp_rdata);
    end
  end

  // slave model update on the rising edge, from the mid-cycle samples
  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (!HRESETn) begin
      s_dp_valid <= 1'b0;
    end else if (mon_ready) begin
      if (mon_done && s_dp_write) smem[s_dp_addr[7:2]] <= mon_wdata;
      s_dp_valid <= mon_acc;
      s_dp_addr  <= mon_addr;
      s_dp_write <= mon_write;
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
  endtask

  task automatic clear_logs();
    rsp_cyc_q.delete();
    rsp_data_q.delete();
    rsp_wr_q.delete();
    acc_q.delete();
  endtask

  // offer a command and hold it until accepted (bounded wait)
  task automatic push_wait(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int n = 0;
    drive_cmd(wr, addr, data);
    while (!bus.cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("push_timeout", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  int t0;

  initial begin
    for (int i = 0; i < 64; i++) smem[i] = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.HREADY    = 1'b1;

    // ---- reset values
    #2;
    check("rst_htrans", 32'(bus.HTRANS), 32'h0);
    check("rst_haddr", bus.HADDR, 32'h0);
    check("rst_hwrite", 32'(bus.HWRITE), 32'h0);
    check("rst_hwdata", bus.HWDATA, 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    repeat (2) tick();
    HRESETn = 1'b1;
    tick();

    // ---- write then read
    clear_logs();
    drive_cmd(1'b1, 32'h5000_0000, 32'h0000_0041);
    tick();                               // E0: write pushed
    t0 = cyc;
    drive_cmd(1'b0, 32'h5000_0000, 32'h0);
    check("wr_htrans", 32'(bus.HTRANS), 32'h2);
    check("wr_haddr", bus.HADDR, 32'h5000_0000);
    check("wr_hwrite", 32'(bus.HWRITE), 32'h1);
    tick();                               // E1: write accepted, read pushed
    bus.cmd_valid = 1'b0;
    check("rd_htrans", 32'(bus.HTRANS), 32'h2);
    check("rd_hwrite", 32'(bus.HWRITE), 32'h0);
    check("wr_hwdata", bus.HWDATA, 32'h0000_0041);
    tick();                               // E2: read accepted, write done
    check("wr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("wr_rsp_write", 32'(bus.rsp_write), 32'h1);
    check("idle_htrans", 32'(bus.HTRANS), 32'h0);
    check("idle_haddr_hold", bus.HADDR, 32'h5000_0000);
    tick();                               // E3: read done
    check("rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("rd_rsp_write", 32'(bus.rsp_write), 32'h0);
    check("rd_rsp_rdata", bus.rsp_rdata, 32'h0000_0041);
    tick();
    check("wr_rd_rsp_low", 32'(bus.rsp_valid), 32'h0);
    check("wr_rd_busy", 32'(bus.busy), 32'h0);
    check("wr_rd_rsp_count", 32'(rsp_cyc_q.size()), 32'd2);
    if (rsp_cyc_q.size() == 2) begin
      check("wr_latency", 32'(rsp_cyc_q[0] - t0), 32'd2);
      check("rd_consecutive", 32'(rsp_cyc_q[1] - rsp_cyc_q[0]), 32'd1);
    end

    // ---- misaligned address
    drive_cmd(1'b1, 32'h5000_0003, 32'h0000_0099);
    tick();
    bus.cmd_valid = 1'b0;
    check("mis_haddr", bus.HADDR, 32'h5000_0000);
    check("mis_hsize", 32'(bus.HSIZE), 32'h2);
    check("mis_hburst", 32'(bus.HBURST), 32'h0);
    repeat (4) tick();
    check("mis_busy", 32'(bus.busy), 32'h0);

    // ---- wait states on a write data phase
    clear_logs();
    drive_cmd(1'b1, 32'h5000_0010, 32'h0000_0011);
    tick();                               // E0: A pushed
    t0 = cyc;
    drive_cmd(1'b1, 32'h5000_0014, 32'h0000_0022);
    tick();                               // E1: A accepted, B pushed
    bus.cmd_valid = 1'b0;
    bus.HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ws_hwdata_%0d", k), bus.HWDATA, 32'h0000_0011);
      check($sformatf("ws_haddr_%0d", k), bus.HADDR, 32'h5000_0014);
      check($sformatf("ws_htrans_%0d", k), 32'(bus.HTRANS), 32'h2);
      check($sformatf("ws_rsp_%0d", k), 32'(bus.rsp_valid), 32'h0);
    end
    bus.HREADY = 1'b1;
    tick();                               // A done, B accepted
    check("ws_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("ws_hwdata_b", bus.HWDATA, 32'h0000_0022);
    repeat (3) tick();
    check("ws_rsp_count", 32'(rsp_cyc_q.size()), 32'd2);
    if (rsp_cyc_q.size() >= 1) check("ws_latency", 32'(rsp_cyc_q[0] - t0), 32'd5);
    check("ws_mem_a", smem[6'h04], 32'h0000_0011);
    check("ws_mem_b", smem[6'h05], 32'h0000_0022);

    // ---- burst fill with the bus stalled
    clear_logs();
    bus.HREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b1, 32'h5000_0100 + 32'(4 * i), 32'h0000_00B0 + 32'(i));
      check($sformatf("fill_ready_%0d", i), 32'(bus.cmd_ready), 32'h1);
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("fill_full_ready", 32'(bus.cmd_ready), 32'h0);
    drive_cmd(1'b1, 32'h5000_0110, 32'h0000_00B4);
    tick();                               // ignored: FIFO full
    check("fill_still_full", 32'(bus.cmd_ready), 32'h0);
    bus.HREADY = 1'b1;
    push_wait(1'b1, 32'h5000_0110, 32'h0000_00B4);
    push_wait(1'b1, 32'h5000_0114, 32'h0000_00B5);
    repeat (8) tick();
    check("fill_acc_count", 32'(acc_q.size()), 32'd6);
    check("fill_rsp_count", 32'(rsp_cyc_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < acc_q.size()) check($sformatf("fill_addr_%0d", i), acc_q[i], 32'h5000_0100 + 32'(4 * i));
      check($sformatf("fill_mem_%0d", i), smem[i], 32'h0000_00B0 + 32'(i));
    end

    // ---- streaming: one push and one pop per cycle
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      drive_cmd(1'b1, 32'h5000_0020 + 32'(4 * i), 32'h0000_0100 + 32'(i));
      check($sformatf("strm_ready_%0d", i), 32'(bus.cmd_ready), 32'h1);
      tick();
    end
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    check("strm_rsp_count", 32'(rsp_cyc_q.size()), 32'd8);
    for (int i = 1; i < rsp_cyc_q.size(); i++)
      check($sformatf("strm_consec_%0d", i), 32'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 32'd1);
    check("strm_mem_7", smem[6'h0F], 32'h0000_0107);

    // ---- reset mid-operation: A in data phase, B and C queued
    drive_cmd(1'b1, 32'h5000_0040, 32'h0000_0AAA);
    tick();
    drive_cmd(1'b1, 32'h5000_0044, 32'h0000_0BBB);
    tick();                               // A accepted, B pushed
    bus.HREADY = 1'b0;
    drive_cmd(1'b0, 32'h5000_0048, 32'h0);
    tick();                               // C pushed
    bus.cmd_valid = 1'b0;
    check("pre_rst_busy", 32'(bus.busy), 32'h1);
    clear_logs();
    #2;
    HRESETn = 1'b0;
    #1;
    check("mid_rst_htrans", 32'(bus.HTRANS), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("mid_rst_hwdata", bus.HWDATA, 32'h0);
    tick();
    tick();
    HRESETn = 1'b1;
    bus.HREADY = 1'b1;
    repeat (6) tick();
    check("post_rst_rsp_count", 32'(rsp_cyc_q.size()), 32'd0);
    check("post_rst_acc_count", 32'(acc_q.size()), 32'd0);
    check("post_rst_ready", 32'(bus.cmd_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
